// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: instruction-fetch sequencer for the SISC core with a prefetch queue and branch redirect.
// Build option IF_FETCH_CNT_EN adds the fetch_cnt output (total pushes, wraps at 16 bits).
//   state | meaning
//   IDLE  | not fetching; queued words are kept and may drain, pc holds
//   RUN   | fetching one word per cycle whenever the queue can accept it
module if_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt,
  output logic [15:0] im_addr,
  input  logic [31:0] im_data,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir_data,
  output logic [15:0] ir_pc,
  output logic        running
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [15:0] fetch_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_t           state;
  logic [15:0]      pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic [15:0]      q_pc   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic             push;
  logic             pop;

  // A redirect blocks both ends of the queue so the shown head is discarded, not consumed.
  assign ir_valid = (count != '0);
  assign pop      = ir_valid && ir_ready && !br_taken;
  assign push     = (state == RUN) && !br_taken && ((count < FULL) || pop);

  assign im_addr  = pc;
  assign ir_data  = ir_valid ? q_data[rd_ptr] : '0;
  assign ir_pc    = ir_valid ? q_pc[rd_ptr]   : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= pc;
      q_data[wr_ptr] <= im_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      running <= 1'b0;
      pc      <= RESET_PC;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
    end else begin
      // halt beats start, and still lands during a redirect; start does not
      if (halt) begin
        state   <= IDLE;
        running <= 1'b0;
      end else if (start && !br_taken) begin
        state   <= RUN;
        running <= 1'b1;
      end

      if (br_taken) begin
        pc     <= br_target;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          pc     <= pc + 16'd1;
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (push && !pop) begin
          count <= count + 1'b1;
        end else if (pop && !push) begin
          count <= count - 1'b1;
        end
      end
    end
  end

`ifdef IF_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
    end else if (push) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end
`endif

endmodule
